// File: rtl/bin_threshold_cfg_ctrl_pkg.sv
// Shared constants and types for the binarization threshold configuration path.
// Covers the packet framing bytes, acknowledge codes, the threshold address map and the parser states.
package bin_cfg_pkg;

    localparam logic [7:0] PKT_HDR = 8'hA5;
    localparam logic [7:0] ACK_OK  = 8'h5A;
    localparam logic [7:0] ACK_ERR = 8'hEE;

    localparam logic [7:0] ADDR_CB_UP   = 8'd0;
    localparam logic [7:0] ADDR_CB_DOWN = 8'd1;
    localparam logic [7:0] ADDR_CR_UP   = 8'd2;
    localparam logic [7:0] ADDR_CR_DOWN = 8'd3;

    localparam int NUM_REGS = 4;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} parse_state_t;

    function automatic logic [7:0] pkt_csum(input logic [7:0] addr, input logic [7:0] data);
        return addr ^ data ^ PKT_HDR;
    endfunction

endpackage

// File: rtl/bin_threshold_cfg_ctrl_if.sv
// UART byte-stream handshake between uart_rx/uart_tx (master) and the config controller (slave).
interface bin_cfg_uart_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output rx_data, output rx_valid, output tx_ready,
                    input  tx_data, input  tx_valid);
    modport slave  (input  rx_data, input  rx_valid, input  tx_ready,
                    output tx_data, output tx_valid);
endinterface

// File: rtl/bin_threshold_cfg_ctrl_pkt_parser.sv
// Threshold-write packet parser: header/addr/data/csum framing, inter-byte timeout, checksum check.
// Result pulses are combinational in the cycle the csum byte (or timeout) is seen.
module bin_cfg_pkt_parser
    import bin_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       bad_pkt,
    output logic       timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    parse_state_t  state_reg, state_next;
    logic [7:0]    addr_reg, addr_next;
    logic [7:0]    data_reg, data_next;
    logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            data_reg    <= '0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        tmo_cnt_next = (state_reg == IDLE) ? '0 : tmo_cnt_reg + CW'(1);
        wr_en        = 1'b0;
        bad_pkt      = 1'b0;
        timeout      = 1'b0;
        wr_addr      = addr_reg[1:0];
        wr_data      = data_reg;

        if (rx_valid) begin
            tmo_cnt_next = '0;
            case (state_reg)
                IDLE: if (rx_data == PKT_HDR) state_next = ADDR;
                ADDR: begin
                    addr_next  = rx_data;
                    state_next = DATA;
                end
                DATA: begin
                    data_next  = rx_data;
                    state_next = CSUM;
                end
                CSUM: begin
                    state_next = IDLE;
                    if (rx_data == pkt_csum(addr_reg, data_reg) && addr_reg <= ADDR_CR_DOWN)
                        wr_en = 1'b1;
                    else
                        bad_pkt = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE && tmo_cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
            // Stalled mid-packet: abandon it silently apart from the error count.
            timeout      = 1'b1;
            state_next   = IDLE;
            tmo_cnt_next = '0;
        end
    end

endmodule

// File: rtl/bin_threshold_cfg_ctrl.sv
// Binarization threshold config controller: shadow bank written from UART packets,
// copied into the active bank on a vsync rising edge so thresholds never change mid-frame.
module bin_threshold_cfg_ctrl
    import bin_cfg_pkg::*;
#(
    parameter int         TIMEOUT_CYC  = 50000,
    parameter logic [7:0] CB_UP_INIT   = 8'hFF,
    parameter logic [7:0] CB_DOWN_INIT = 8'h00,
    parameter logic [7:0] CR_UP_INIT   = 8'hFF,
    parameter logic [7:0] CR_DOWN_INIT = 8'hAF
) (
    input  logic           clk,
    input  logic           rst,
    bin_cfg_uart_if.slave  uart,
    input  logic           ycbcr_vsync,
    output logic [7:0]     data1_up,
    output logic [7:0]     data1_down,
    output logic [7:0]     data2_up,
    output logic [7:0]     data2_down,
    output logic           cfg_pending,
    output logic [7:0]     err_cnt
);

    logic       wr_en, bad_pkt, timeout;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    bin_cfg_pkt_parser #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_parser (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (uart.rx_data),
        .rx_valid (uart.rx_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .bad_pkt  (bad_pkt),
        .timeout  (timeout)
    );

    logic       vsync_d_reg, cfg_pending_reg, tx_valid_reg;
    logic [7:0] tx_data_reg, err_cnt_reg, err_cnt_next;
    logic       vs_rise, commit, ack_due, ack_load, ack_drop;
    logic [1:0] err_inc;
    logic [8:0] err_sum;
    logic [7:0] active_val [NUM_REGS];

    assign vs_rise  = ycbcr_vsync & ~vsync_d_reg;
    assign commit   = vs_rise & cfg_pending_reg;
    assign ack_due  = wr_en | bad_pkt;
    assign ack_load = ack_due & (~tx_valid_reg | uart.tx_ready);
    assign ack_drop = ack_due & ~ack_load;

    // Commit reads the pre-edge shadow, so a same-cycle write waits for the next frame.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bank
        localparam logic [7:0] INIT = (gi == 0) ? CB_UP_INIT   :
                                      (gi == 1) ? CB_DOWN_INIT :
                                      (gi == 2) ? CR_UP_INIT   : CR_DOWN_INIT;
        logic [7:0] shadow_reg, active_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_reg <= INIT;
                active_reg <= INIT;
            end else begin
                if (wr_en && wr_addr == 2'(gi)) shadow_reg <= wr_data;
                if (commit) active_reg <= shadow_reg;
            end
        end

        assign active_val[gi] = active_reg;
    end

    assign err_inc      = 2'(bad_pkt) + 2'(ack_drop) + 2'(timeout);
    assign err_sum      = {1'b0, err_cnt_reg} + 9'(err_inc);
    assign err_cnt_next = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d_reg     <= 1'b0;
            cfg_pending_reg <= 1'b0;
            tx_valid_reg    <= 1'b0;
            tx_data_reg     <= '0;
            err_cnt_reg     <= '0;
        end else begin
            vsync_d_reg <= ycbcr_vsync;
            err_cnt_reg <= err_cnt_next;
            if (wr_en)       cfg_pending_reg <= 1'b1;
            else if (commit) cfg_pending_reg <= 1'b0;
            if (ack_load) begin
                tx_valid_reg <= 1'b1;
                tx_data_reg  <= wr_en ? ACK_OK : ACK_ERR;
            end else if (tx_valid_reg && uart.tx_ready) begin
                tx_valid_reg <= 1'b0;
            end
        end
    end

    assign uart.tx_data  = tx_data_reg;
    assign uart.tx_valid = tx_valid_reg;
    assign data1_up      = active_val[0];
    assign data1_down    = active_val[1];
    assign data2_up      = active_val[2];
    assign data2_down    = active_val[3];
    assign cfg_pending   = cfg_pending_reg;
    assign err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_bin_threshold_cfg_ctrl.sv
// Scoreboard bench for bin_threshold_cfg_ctrl: directed packets push expected acks/threshold
// sets into queues; independent monitors pop and compare whenever the DUT presents them.
module tb_bin_threshold_cfg_ctrl;

    localparam int TMO = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0;
    logic [7:0] d1u, d1d, d2u, d2d, err_cnt;
    logic       cfg_pending;

    always #5 clk = ~clk;

    bin_cfg_uart_if u_if();

    bin_threshold_cfg_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart        (u_if.slave),
        .ycbcr_vsync (vsync),
        .data1_up    (d1u),
        .data1_down  (d1d),
        .data2_up    (d2u),
        .data2_down  (d2d),
        .cfg_pending (cfg_pending),
        .err_cnt     (err_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    int          ack_accepts = 0;
    logic [7:0]  ack_q [$];
    logic [31:0] thr_q [$];
    logic [31:0] thr_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("check %s ok value=%h", name, act);
        end
    endtask

    // Ack monitor: every accepted handshake must match the oldest expected ack.
    always @(negedge clk) begin
        if (!rst && u_if.tx_valid && u_if.tx_ready) begin
            ack_accepts++;
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected actual=%h required=none", u_if.tx_data);
            end else begin
                chk("ack", {24'h0, u_if.tx_data}, {24'h0, ack_q.pop_front()});
            end
        end
    end

    // Threshold monitor: every change of the active bank outside reset must be expected.
    always @(negedge clk) begin
        logic [31:0] cur;
        cur = {d1u, d1d, d2u, d2d};
        if (rst) begin
            thr_prev = cur;
        end else if (cur !== thr_prev) begin
            if (thr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL thr_unexpected actual=%h required=%h", cur, thr_prev);
            end else begin
                chk("thr_commit", cur, thr_q.pop_front());
            end
            thr_prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        u_if.rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d);
        send_byte(c);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        idle(2);
    endtask

    task automatic vsync_end();
        vsync = 1'b0;
        idle(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        int acc0;
        u_if.rx_data  = 8'h00;
        u_if.rx_valid = 1'b0;
        u_if.tx_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);

        chk("rst_thr", {d1u, d1d, d2u, d2d}, 32'hFF00FFAF);
        chk("rst_tx_valid", {31'h0, u_if.tx_valid}, 32'h0);
        chk("rst_pending", {31'h0, cfg_pending}, 32'h0);
        chk("rst_err", {24'h0, err_cnt}, 32'h0);

        // Good write to Cr down
        ack_q.push_back(8'h5A);
        send_pkt(8'h03, 8'h80, 8'h26);
        chk("good_pending", {31'h0, cfg_pending}, 32'h1);
        idle(3);
        chk("good_hold_d2d", {24'h0, d2d}, 32'h000000AF);
        thr_q.push_back(32'hFF00FF80);
        vsync_pulse();
        chk("good_d2d", {24'h0, d2d}, 32'h00000080);
        chk("good_cleared", {31'h0, cfg_pending}, 32'h0);
        vsync_end();

        // Bad checksum, then bad address with valid checksum
        ack_q.push_back(8'hEE);
        send_pkt(8'h01, 8'h10, 8'h00);
        idle(2);
        chk("badcs_err", {24'h0, err_cnt}, 32'h1);
        chk("badcs_pending", {31'h0, cfg_pending}, 32'h0);
        ack_q.push_back(8'hEE);
        send_pkt(8'h07, 8'h10, 8'hB2);
        idle(2);
        chk("badaddr_err", {24'h0, err_cnt}, 32'h2);
        vsync_pulse();
        chk("bad_no_commit", {d1u, d1d, d2u, d2d}, 32'hFF00FF80);
        vsync_end();

        // Timeout discards a stalled packet
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        idle(TMO + 2);
        chk("tmo_err", {24'h0, err_cnt}, 32'h1);
        ack_q.push_back(8'h5A);
        send_pkt(8'h00, 8'h40, 8'hE5);
        idle(2);
        chk("tmo_err_after", {24'h0, err_cnt}, 32'h1);
        thr_q.push_back(32'h4000FFAF);
        vsync_pulse();
        chk("tmo_d1u", {24'h0, d1u}, 32'h00000040);
        vsync_end();

        // Ack backpressure: second ack dropped, both writes land
        do_reset();
        u_if.tx_ready = 1'b0;
        ack_q.push_back(8'h5A);
        send_pkt(8'h00, 8'h11, 8'hB4);
        idle(2);
        chk("bp_valid", {31'h0, u_if.tx_valid}, 32'h1);
        send_pkt(8'h02, 8'h22, 8'h85);
        idle(3);
        chk("bp_data_stable", {24'h0, u_if.tx_data}, 32'h0000005A);
        chk("bp_err", {24'h0, err_cnt}, 32'h1);
        chk("bp_pending", {31'h0, cfg_pending}, 32'h1);
        thr_q.push_back(32'h110022AF);
        vsync_pulse();
        chk("bp_thr", {d1u, d1d, d2u, d2d}, 32'h110022AF);
        vsync_end();
        acc0 = ack_accepts;
        u_if.tx_ready = 1'b1;
        idle(4);
        chk("bp_one_accept", 32'(ack_accepts - acc0), 32'h1);
        chk("bp_released", {31'h0, u_if.tx_valid}, 32'h0);

        // Write evaluated in the same cycle as the vsync rising edge
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h20);
        ack_q.push_back(8'h5A);
        u_if.rx_data  = 8'h85;
        u_if.rx_valid = 1'b1;
        vsync         = 1'b1;
        @(posedge clk);
        #1;
        u_if.rx_valid = 1'b0;
        idle(2);
        chk("coll_d1u_held", {24'h0, d1u}, 32'h000000FF);
        chk("coll_pending", {31'h0, cfg_pending}, 32'h1);
        vsync_end();
        thr_q.push_back(32'h2000FFAF);
        vsync_pulse();
        chk("coll_d1u", {24'h0, d1u}, 32'h00000020);
        chk("coll_cleared", {31'h0, cfg_pending}, 32'h0);
        vsync_end();

        idle(3);
        chk("ack_q_empty", 32'(ack_q.size()), 32'h0);
        chk("thr_q_empty", 32'(thr_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
